uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of byte entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the pointer width; it SHALL equal log2(DEPTH).
REQ-003 The block SHALL have port baud_clk, input, 1 bit: the single clock, shared with the downstream transmitter. All logic uses the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: a request to push wr_data.
REQ-006 The block SHALL have port wr_data, input, 8 bits: the byte to enqueue.
REQ-007 The block SHALL have port full, output, 1 bit: high when count == DEPTH.
REQ-008 The block SHALL have port empty, output, 1 bit: high when count == 0.
REQ-009 The block SHALL have port count, output, ADDR_W+1 bits: the number of stored bytes.
REQ-010 The block SHALL have port overflow, output, 1 bit: a one-cycle pulse that marks a dropped write.
REQ-011 The block SHALL have port tx_data, output, 8 bits: the byte presented to the transmitter's Data input.
REQ-012 The block SHALL have port tx_start, output, 1 bit: drives the transmitter's start input.
REQ-013 The block SHALL have port tx_busy, input, 1 bit: driven by the transmitter's busy output.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH x 8 bits, with write pointer wr_ptr and read pointer rd_ptr, each ADDR_W bits wide.
REQ-015 Both pointers SHALL wrap from DEPTH-1 to 0 by natural overflow.
REQ-016 A write SHALL be accepted when wr_en=1 and full=0; on acceptance, mem[wr_ptr] <= wr_data and wr_ptr increments.
REQ-017 When wr_en=1 and full=1, the write SHALL be dropped: no change to storage, pointers or count, and overflow=1 for the next cycle.
REQ-018 full SHALL be evaluated before the edge, so a write while full is dropped even if a pop occurs in the same cycle.
REQ-019 count SHALL change as follows: +1 on an accepted write only; -1 on a pop only; unchanged when both occur in the same cycle.
REQ-020 full and empty SHALL be combinational decodes of count.
REQ-021 The launch FSM SHALL have three states: S_IDLE, S_LAUNCH and S_WAIT.
REQ-022 In S_IDLE, when empty=0 and tx_busy=0, the block SHALL pop: tx_data <= mem[rd_ptr], rd_ptr increments, tx_start <= 1, and the FSM moves to S_LAUNCH.
REQ-023 In S_IDLE, if the pop condition is not met, the FSM SHALL stay in S_IDLE with tx_start=0.
REQ-024 In S_LAUNCH, tx_start SHALL stay at 1 until tx_busy=1 is sampled; then tx_start <= 0 and the FSM moves to S_WAIT.
REQ-025 In S_WAIT, when tx_busy=0 is sampled, the FSM SHALL move to S_IDLE.
REQ-026 tx_data SHALL be held constant from the pop until the FSM returns to S_IDLE; the transmitter reads Data bit-serially during the frame.
REQ-027 At most one byte SHALL be in flight at a time, and a pop SHALL never occur outside S_IDLE.
REQ-028 Latency: a write accepted at edge N into an empty FIFO, with the FSM idle and tx_busy=0, SHALL produce tx_start=1 and tx_data valid after edge N+1.
REQ-029 Back-to-back bytes SHALL launch on the first S_IDLE cycle with tx_busy=0, with no additional gap.
REQ-030 A write to an empty FIFO and a pop in the same cycle SHALL be impossible, because the pop requires empty=0 before the edge.
REQ-031 An unreachable FSM encoding SHALL return to S_IDLE with tx_start=0.

Reset
REQ-032 When reset=1 at a baud_clk edge, the block SHALL set: wr_ptr=0, rd_ptr=0, count=0, state=S_IDLE, tx_start=0, tx_data=8'h00 and overflow=0.
REQ-033 After reset, empty=1 and full=0 SHALL follow.
REQ-034 Reset SHALL have priority over wr_en and pops in the same cycle.
REQ-035 Memory contents need not be cleared on reset.
REQ-036 Reset mid-frame SHALL abandon the in-flight byte and discard all queued bytes; the transmitter is reset by the same signal.

Verification
REQ-037 Single byte: write 8'hA5 at edge N into an empty FIFO with tx_busy=0 -> tx_start=1 and tx_data=8'hA5 after N+1; with the transmitter model, the tx line serialises start bit, A5 LSB-first, then stop; count returns to 0.
REQ-038 Fill/overflow: write 16 bytes 8'h00..8'h0F with tx_busy held at 1 -> full=1 and count=16; a 17th write of 8'hFF -> overflow pulses once, count stays 16, and 8'hFF is never transmitted.
REQ-039 Ordering and wrap: push 40 bytes in bursts of 10 while the transmitter drains -> all 40 are transmitted in FIFO order, with both pointers wrapping at least twice.
REQ-040 Simultaneous push and pop: with count=3 in S_IDLE, tx_busy=0 and wr_en=1 -> count stays 3, and the popped byte is the oldest entry.
REQ-041 Data stability: during a frame, tx_data stays constant from the pop until tx_busy falls, including while new writes arrive.
REQ-042 Reset mid-frame: assert reset during the transmitter's data bits with count=5 -> the next cycle shows tx_start=0, count=0, empty=1 and state S_IDLE, and no queued byte is sent afterwards.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte-push and transmitter-launch signals shared by the TX FIFO and its neighbours.
// master = producer/transmitter side, slave = FIFO side.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, overflow, tx_data, tx_start
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, overflow, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: circular buffer plus a launch FSM that
// hands one byte at a time to the transmitter and holds it for the whole frame.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            baud_clk,
    input  logic            reset,
    uart_tx_fifo_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    state_t            state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              overflow_q, overflow_d;
    logic              full, empty, wr_accept, pop;

    // full is decoded from the registered count, so a write while full is
    // dropped even if a pop frees a slot on the same edge.
    always_comb begin
        full       = (count_q == (ADDR_W+1)'(DEPTH));
        empty      = (count_q == '0);
        wr_accept  = bus.wr_en && !full;
        overflow_d = bus.wr_en && full;
        wr_ptr_d   = wr_accept ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        rd_ptr_d   = rd_ptr_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_start_d = 1'b0;
                if (!empty && !bus.tx_busy) begin
                    pop        = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                    tx_start_d = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (bus.tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.tx_busy) state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                tx_start_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not cleared by reset; the pointers make stale bytes unreachable.
    always_ff @(posedge baud_clk) begin
        if (!reset && wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a one-bit-per-clock transmitter model.
module tb_uart_tx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic       baud_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       hold_busy = 1'b0;
    logic       model_busy = 1'b0;
    logic       tx_line = 1'b1;
    int         phase = 0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] sent [$];
    int         total = 0;
    int         bad = 0;

    uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .baud_clk (baud_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 baud_clk = ~baud_clk;

    assign bus.tx_busy = model_busy | hold_busy;

    // Transmitter: start bit, 8 data bits LSB-first read live from tx_data, stop bit.
    always @(posedge baud_clk) begin
        if (reset) begin
            phase      <= 0;
            model_busy <= 1'b0;
            tx_line    <= 1'b1;
        end else if (phase == 0) begin
            if (bus.tx_start && !model_busy) begin
                model_busy <= 1'b1;
                tx_line    <= 1'b0;
                phase      <= 1;
            end
        end else if (phase >= 1 && phase <= 8) begin
            tx_line                <= bus.tx_data[3'(phase - 1)];
            shreg[3'(phase - 1)]   <= bus.tx_data[3'(phase - 1)];
            phase                  <= phase + 1;
        end else if (phase == 9) begin
            tx_line <= 1'b1;
            phase   <= 10;
        end else begin
            model_busy <= 1'b0;
            phase      <= 0;
            sent.push_back(shreg);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge baud_clk); #1;
        reset = 1'b0;
        sent.delete();
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(posedge baud_clk); #1;
        bus.wr_en   = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge baud_clk); #1;
            if (bus.count == '0 && phase == 0 && !bus.tx_start && !bus.tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge baud_clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.full); end
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
    endtask

    task automatic test_single_byte();
        logic [9:0] exp_line;
        bit ok;
        do_reset();
        push(8'hA5);
        @(posedge baud_clk); #1;
        total++; if (bus.tx_start !== 1'b1) begin bad++; $display("FAIL single_tx_start got=%b want=1", bus.tx_start); end
        total++; if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_tx_data got=%h want=a5", bus.tx_data); end
        exp_line = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge baud_clk); #1;
            total++;
            if (tx_line !== exp_line[i]) begin
                bad++; $display("FAIL single_line bit%0d got=%b want=%b", i, tx_line, exp_line[i]);
            end
        end
        drain(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_drain timeout got=busy want=idle"); end
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL single_count got=%0d want=0", bus.count); end
        total++;
        if (sent.size() != 1 || sent[0] !== 8'hA5) begin
            bad++; $display("FAIL single_sent got_n=%0d want_n=1 byte a5", sent.size());
        end
    endtask

    task automatic test_fill_overflow();
        bit ok;
        hold_busy = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", bus.full); end
        total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d want=16", bus.count); end
        total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b want=0", bus.empty); end
        push(8'hFF);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", bus.overflow); end
        total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", bus.count); end
        @(posedge baud_clk); #1;
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", bus.overflow); end
        hold_busy = 1'b0;
        drain(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL fill_drain timeout got=busy want=idle"); end
        total++; if (sent.size() != 16) begin bad++; $display("FAIL fill_sent_n got=%0d want=16", sent.size()); end
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            total++;
            if (sent[i] !== 8'(i)) begin bad++; $display("FAIL fill_order idx%0d got=%h want=%h", i, sent[i], 8'(i)); end
        end
    endtask

    task automatic test_wrap_order();
        bit ok;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            ok = 1'b0;
            for (int t = 0; t < 300; t++) begin
                if (bus.count <= 5'd6) begin ok = 1'b1; break; end
                @(posedge baud_clk); #1;
            end
            total++; if (!ok) begin bad++; $display("FAIL wrap_space burst%0d got=%0d want<=6", b, bus.count); end
            for (int k = 0; k < 10; k++) push(8'(8'h80 + b * 10 + k));
        end
        drain(800, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_drain timeout got=busy want=idle"); end
        total++; if (sent.size() != 40) begin bad++; $display("FAIL wrap_sent_n got=%0d want=40", sent.size()); end
        for (int i = 0; i < 40 && i < sent.size(); i++) begin
            total++;
            if (sent[i] !== 8'(8'h80 + i)) begin
                bad++; $display("FAIL wrap_order idx%0d got=%h want=%h", i, sent[i], 8'(8'h80 + i));
            end
        end
    endtask

    task automatic test_push_pop_stability();
        logic [7:0] exp [6];
        bit ok, seen;
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        exp[3] = 8'h44; exp[4] = 8'h55; exp[5] = 8'h66;
        hold_busy = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) push(exp[i]);
        total++; if (bus.count !== 5'd3) begin bad++; $display("FAIL pp_pre_count got=%0d want=3", bus.count); end
        hold_busy = 1'b0;
        push(8'h44);
        total++; if (bus.count !== 5'd3) begin bad++; $display("FAIL pp_count got=%0d want=3", bus.count); end
        total++; if (bus.tx_start !== 1'b1) begin bad++; $display("FAIL pp_tx_start got=%b want=1", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h11) begin bad++; $display("FAIL pp_tx_data got=%h want=11", bus.tx_data); end
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.wr_en   = (c < 2);
            bus.wr_data = (c == 0) ? 8'h55 : 8'h66;
            @(posedge baud_clk); #1;
            if (bus.tx_busy) seen = 1'b1;
            else if (seen) break;
            total++;
            if (bus.tx_data !== 8'h11) begin bad++; $display("FAIL stable_tx_data cyc%0d got=%h want=11", c, bus.tx_data); end
        end
        bus.wr_en = 1'b0;
        total++; if (!seen) begin bad++; $display("FAIL stable_frame got=nobusy want=busy"); end
        drain(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL pp_drain timeout got=busy want=idle"); end
        total++; if (sent.size() != 6) begin bad++; $display("FAIL pp_sent_n got=%0d want=6", sent.size()); end
        for (int i = 0; i < 6 && i < sent.size(); i++) begin
            total++;
            if (sent[i] !== exp[i]) begin bad++; $display("FAIL pp_order idx%0d got=%h want=%h", i, sent[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        hold_busy = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
        hold_busy = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(posedge baud_clk); #1;
            if (phase == 3) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL mid_frame_start timeout got=noframe want=frame"); end
        total++; if (bus.count !== 5'd5) begin bad++; $display("FAIL mid_pre_count got=%0d want=5", bus.count); end
        reset = 1'b1;
        @(posedge baud_clk); #1;
        reset = 1'b0;
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL mid_tx_start got=%b want=0", bus.tx_start); end
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", bus.count); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b want=1", bus.empty); end
        total++; if (2'(dut.state_q) !== 2'd0) begin bad++; $display("FAIL mid_state got=%0d want=0", 2'(dut.state_q)); end
        repeat (60) @(posedge baud_clk);
        #1;
        total++; if (sent.size() != 0) begin bad++; $display("FAIL mid_no_send got_n=%0d want_n=0", sent.size()); end
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL mid_idle_start got=%b want=0", bus.tx_start); end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_wrap_order();
        test_push_pop_stability();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
